// File: rtl/qic117_pkg.sv
// Shared types, error codes and time-to-clock helpers for the QIC-117 command decoder.
package qic117_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_PUSH  = 2'd2
   } qic_state_t;

   localparam logic [1:0] QIC_ERR_OK    = 2'd0;
   localparam logic [1:0] QIC_ERR_RANGE = 2'd1;
   localparam logic [1:0] QIC_ERR_GAP   = 2'd2;
   localparam logic [1:0] QIC_ERR_SEL   = 2'd3;

   function automatic int unsigned us_to_clks(input longint unsigned clk_hz,
                                              input longint unsigned us);
      longint unsigned v;
      v = (clk_hz * us) / 64'd1_000_000;
      return v[31:0];
   endfunction

   function automatic int unsigned ms_to_clks(input longint unsigned clk_hz,
                                              input longint unsigned ms);
      longint unsigned v;
      v = (clk_hz * ms) / 64'd1_000;
      return v[31:0];
   endfunction

endpackage

// File: rtl/qic117_cmd_fifo.sv
// First-word-fall-through command FIFO with occupancy level and sticky overflow flag.
module qic117_cmd_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   output logic                       o_valid,
   output logic [WIDTH-1:0]           o_dout,
   output logic [$clog2(DEPTH+1)-1:0] o_level,
   output logic                       o_overflow
);

   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             r_overflow;

   logic w_empty;
   logic w_full;
   logic w_do_pop;
   logic w_do_push;
   logic w_drop;

   assign w_empty   = (r_level == '0);
   assign w_full    = (r_level == LVL_W'(DEPTH));
   assign w_do_pop  = i_pop & ~w_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_do_push = i_push & (~w_full | w_do_pop);
   assign w_drop    = i_push & w_full & ~w_do_pop;

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_level <= r_level + LVL_W'(w_do_push) - LVL_W'(w_do_pop);
         if (w_drop)
            r_overflow <= 1'b1;
      end
   end

   assign o_valid    = ~w_empty;
   assign o_dout     = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_level    = r_level;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/qic117_cmd_decoder.sv
// QIC-117 tape-mode command decoder: debounces STEP, counts pulses into sequences,
// validates each closed sequence and queues it as a tagged entry for the tape controller.
module qic117_cmd_decoder
   import qic117_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 200_000_000,
   parameter int unsigned TIMEOUT_MS  = 100,
   parameter int unsigned DEBOUNCE_US = 10,
   parameter int unsigned MIN_GAP_US  = 2000,
   parameter int          CNT_WIDTH   = 6,
   parameter int unsigned MAX_CMD     = 48,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            tape_mode_en,
   input  logic                            step_in,
   input  logic [1:0]                      drive_sel,
   output logic                            cmd_valid,
   input  logic                            cmd_ready,
   output logic [CNT_WIDTH-1:0]            cmd_code,
   output logic [1:0]                      cmd_drive,
   output logic [1:0]                      cmd_err,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
   output logic                            overflow,
   output logic [CNT_WIDTH-1:0]            pulse_count,
   output logic                            counting,
   output logic                            timeout_pending
);

   localparam int unsigned TIMEOUT_CLKS  = ms_to_clks(64'(CLK_FREQ_HZ), 64'(TIMEOUT_MS));
   localparam int unsigned DEBOUNCE_CLKS = us_to_clks(64'(CLK_FREQ_HZ), 64'(DEBOUNCE_US));
   localparam int unsigned MIN_GAP_CLKS  = us_to_clks(64'(CLK_FREQ_HZ), 64'(MIN_GAP_US));

   localparam int TO_W  = (TIMEOUT_CLKS  > 1) ? $clog2(TIMEOUT_CLKS)  : 1;
   localparam int DB_W  = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;
   localparam int GAP_W = (MIN_GAP_CLKS  > 1) ? $clog2(MIN_GAP_CLKS)  : 1;
   localparam int ENT_W = CNT_WIDTH + 4;

   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CLKS - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_GAP_CLKS - 1);

   logic            r_step_s1;
   logic            r_step_s2;
   logic            r_step_deb;
   logic [1:0]      r_sel_s1;
   logic [1:0]      r_sel_s2;
   logic [DB_W-1:0] r_db_cnt;

   logic            w_db_accept;
   logic            w_step_rise;

   assign w_db_accept = (r_step_s2 != r_step_deb) && (r_db_cnt == DB_LAST);
   // Rise is flagged in the cycle the debounced value is loaded, so the FSM acts on that same edge.
   assign w_step_rise = w_db_accept & r_step_s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_step_s1  <= 1'b0;
         r_step_s2  <= 1'b0;
         r_step_deb <= 1'b0;
         r_sel_s1   <= '0;
         r_sel_s2   <= '0;
         r_db_cnt   <= '0;
      end else begin
         r_step_s1 <= step_in;
         r_step_s2 <= r_step_s1;
         r_sel_s1  <= drive_sel;
         r_sel_s2  <= r_sel_s1;
         if (r_step_s2 == r_step_deb) begin
            r_db_cnt <= '0;
         end else if (w_db_accept) begin
            r_step_deb <= r_step_s2;
            r_db_cnt   <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   qic_state_t           r_state;
   logic [CNT_WIDTH-1:0] r_count;
   logic [1:0]           r_drive;
   logic                 r_gap_err;
   logic                 r_sel_err;
   logic [GAP_W-1:0]     r_gap_tmr;
   logic [TO_W-1:0]      r_to_tmr;

   qic_state_t           w_state_next;
   logic [CNT_WIDTH-1:0] w_count_next;
   logic [1:0]           w_drive_next;
   logic                 w_gap_err_next;
   logic                 w_sel_err_next;
   logic [GAP_W-1:0]     w_gap_tmr_next;
   logic [TO_W-1:0]      w_to_tmr_next;
   logic                 w_push;
   logic [1:0]           w_err;

   always_comb begin
      w_state_next   = r_state;
      w_count_next   = r_count;
      w_drive_next   = r_drive;
      w_gap_err_next = r_gap_err;
      w_sel_err_next = r_sel_err;
      w_gap_tmr_next = r_gap_tmr;
      w_to_tmr_next  = r_to_tmr;
      w_push         = 1'b0;

      case (r_state)
         ST_COUNT: begin
            if (w_step_rise) begin
               if (r_count != '1)
                  w_count_next = r_count + 1'b1;
               if (r_gap_tmr < GAP_LAST)
                  w_gap_err_next = 1'b1;
               w_gap_tmr_next = '0;
               w_to_tmr_next  = '0;
            end else begin
               if (r_sel_s2 != r_drive)
                  w_sel_err_next = 1'b1;
               if (r_gap_tmr != GAP_LAST)
                  w_gap_tmr_next = r_gap_tmr + 1'b1;
               if (r_to_tmr == TO_LAST)
                  w_state_next = ST_PUSH;
               else
                  w_to_tmr_next = r_to_tmr + 1'b1;
            end
         end
         ST_PUSH: begin
            w_push       = 1'b1;
            w_state_next = ST_IDLE;
            w_count_next = '0;
         end
         default: w_state_next = ST_IDLE;
      endcase

      // A rise in IDLE or in the PUSH cycle opens a fresh sequence.
      if ((r_state != ST_COUNT) && w_step_rise) begin
         w_state_next   = ST_COUNT;
         w_count_next   = CNT_WIDTH'(1);
         w_drive_next   = r_sel_s2;
         w_gap_err_next = 1'b0;
         w_sel_err_next = 1'b0;
         w_gap_tmr_next = '0;
         w_to_tmr_next  = '0;
      end

      if (!tape_mode_en) begin
         w_state_next   = ST_IDLE;
         w_count_next   = '0;
         w_gap_err_next = 1'b0;
         w_sel_err_next = 1'b0;
         w_gap_tmr_next = '0;
         w_to_tmr_next  = '0;
         w_push         = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_drive   <= '0;
         r_gap_err <= 1'b0;
         r_sel_err <= 1'b0;
         r_gap_tmr <= '0;
         r_to_tmr  <= '0;
      end else begin
         r_state   <= w_state_next;
         r_count   <= w_count_next;
         r_drive   <= w_drive_next;
         r_gap_err <= w_gap_err_next;
         r_sel_err <= w_sel_err_next;
         r_gap_tmr <= w_gap_tmr_next;
         r_to_tmr  <= w_to_tmr_next;
      end
   end

   always_comb begin
      w_err = QIC_ERR_OK;
      if (r_sel_err)
         w_err = QIC_ERR_SEL;
      else if (r_gap_err)
         w_err = QIC_ERR_GAP;
      else if (32'(r_count) > MAX_CMD)
         w_err = QIC_ERR_RANGE;
   end

   logic [ENT_W-1:0] w_head;

   qic117_cmd_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_flush    (~tape_mode_en),
      .i_push     (w_push),
      .i_din      ({r_count, r_drive, w_err}),
      .i_pop      (cmd_ready),
      .o_valid    (cmd_valid),
      .o_dout     (w_head),
      .o_level    (fifo_level),
      .o_overflow (overflow)
   );

   assign cmd_code        = w_head[ENT_W-1 -: CNT_WIDTH];
   assign cmd_drive       = w_head[3:2];
   assign cmd_err         = w_head[1:0];
   assign pulse_count     = r_count;
   assign counting        = (r_state != ST_IDLE);
   assign timeout_pending = (r_state == ST_COUNT);

endmodule
